// File: rtl/window_sum_decoder_pkg.sv
// rtl/window_sum_decoder_pkg.sv - shared packing, p codes and decode helper for the window-sum codec
package window_sum_decoder_pkg;

    localparam int WINDOW_SIZE_DEFAULT = 4;

    localparam int X_LSB = 0;
    localparam int Y_LSB = 2;
    localparam int T_LSB = 4;
    localparam int P_LSB = 6;

    localparam logic [1:0] P_VALID = 2'b11;
    localparam logic [1:0] P_CLEAR = 2'b10;

    // Field order matches the offsets above: p in [7:6], t in [5:4], y in [3:2], x in [1:0].
    typedef struct packed {
        logic [1:0] p;
        logic [1:0] t;
        logic [1:0] y;
        logic [1:0] x;
    } word_t;

    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_ACCEPT = 2'd2
    } op_t;

    // The p codes are mutually exclusive, so a plain lookup is enough.
    function automatic op_t decode_p(input logic [1:0] p);
        case (p)
            P_VALID: return OP_ACCEPT;
            P_CLEAR: return OP_CLEAR;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/window_sum_decoder_if.sv
// rtl/window_sum_decoder_if.sv - packed word bus between link source and decoder
interface window_sum_decoder_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/window_sum_decoder_lane.sv
// rtl/window_sum_decoder_lane.sv - one 2-bit channel: history, previous sum and difference/add path
module window_sum_decoder_lane #(
    parameter int WINDOW_SIZE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       acc,
    input  logic [1:0] sum_in,
    output logic [1:0] rec
);

    // hist[0] is the oldest recovered sample, the one leaving the encoder window.
    logic [1:0] hist [WINDOW_SIZE];
    logic [1:0] s_prev;

    // Mod-4 wrap is intentional: first difference plus the sample dropping out of the window.
    assign rec = (sum_in - s_prev) + hist[0];

    // Shift the history on every accepted word; reset and soft clear return to the common zero state.
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                hist[i] <= 2'd0;
            end
            s_prev <= 2'd0;
        end else if (acc) begin
            for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
                hist[i] <= hist[i+1];
            end
            hist[WINDOW_SIZE-1] <= rec;
            s_prev              <= sum_in;
        end
    end

endmodule

// File: rtl/window_sum_decoder.sv
// rtl/window_sum_decoder.sv - windowed moving-sum decoder: p decode, count/primed and output register
module window_sum_decoder
    import window_sum_decoder_pkg::*;
#(
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEFAULT  // must match the encoder, 2..8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    window_sum_decoder_if.slave  bus
);

    localparam int              CW   = $clog2(WINDOW_SIZE) + 1;
    localparam logic [CW-1:0]   FULL = CW'(WINDOW_SIZE);

    word_t         word;
    op_t           op;
    logic          clr;
    logic          acc;
    logic [1:0]    rec_x;
    logic [1:0]    rec_y;
    logic [1:0]    rec_t;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [7:0]    out_q;

    assign word = word_t'(bus.ui_in);
    assign op   = decode_p(word.p);
    assign clr  = (op == OP_CLEAR);
    assign acc  = (op == OP_ACCEPT);

    window_sum_decoder_lane #(.WINDOW_SIZE(WINDOW_SIZE)) u_lane_x (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc(acc), .sum_in(word.x), .rec(rec_x)
    );
    window_sum_decoder_lane #(.WINDOW_SIZE(WINDOW_SIZE)) u_lane_y (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc(acc), .sum_in(word.y), .rec(rec_y)
    );
    window_sum_decoder_lane #(.WINDOW_SIZE(WINDOW_SIZE)) u_lane_t (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc(acc), .sum_in(word.t), .rec(rec_t)
    );

    // Saturating accepted-word count; primed is derived from the value it is about to hold.
    always_comb begin
        count_next = count;
        if (count != FULL) begin
            count_next = count + 1'b1;
        end
    end

    // Output register: accept loads fresh fields, idle only drops out_valid, clear zeroes everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
            out_q <= 8'h00;
        end else begin
            case (op)
                OP_CLEAR: begin
                    count <= '0;
                    out_q <= 8'h00;
                end
                OP_ACCEPT: begin
                    count <= count_next;
                    out_q <= {(count_next == FULL), 1'b1, rec_t, rec_y, rec_x};
                end
                default: begin
                    out_q[6] <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uo_out = out_q;

endmodule

// File: tb/tb_window_sum_decoder.sv
// tb/tb_window_sum_decoder.sv - scoreboard bench for window_sum_decoder
module tb_window_sum_decoder;
    import window_sum_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   failed    = 0;
    logic mon_en    = 1'b0;
    logic [7:0] exp_q [$];

    window_sum_decoder_if bus ();

    window_sum_decoder #(.WINDOW_SIZE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mon_en && bus.uo_out[6] === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_valid: got %h, no word pending", bus.uo_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.uo_out !== e) begin
                    failed++;
                    $display("FAIL scoreboard: got %h expected %h", bus.uo_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        bus.ui_in  = 8'h00;
        @(negedge clk);
        rst_n      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        bus.ui_in = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.uo_out !== 8'h00) begin
                failed++;
                $display("FAIL reset_hold[%0d]: got %h expected 00", i, bus.uo_out);
            end
        end
        rst_n     = 1'b0;
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (bus.uo_out !== 8'h00) begin
            failed++;
            $display("FAIL reset_release: got %h expected 00", bus.uo_out);
        end
    endtask

    task automatic test_basic();
        logic [1:0] sums [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [1:0] recs [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if (bus.uo_out[6] !== 1'b1) begin
                    failed++;
                    $display("FAIL basic_valid_run[%0d]: got %b expected 1", i, bus.uo_out[6]);
                end
            end
            exp_q.push_back({(i >= 3), 1'b1, recs[i], recs[i], recs[i]});
            bus.ui_in = {P_VALID, sums[i], sums[i], sums[i]};
        end
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (bus.uo_out[6] !== 1'b0) begin
            failed++;
            $display("FAIL basic_valid_drop: got %b expected 0", bus.uo_out[6]);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_idle_stall();
        logic [1:0] sums [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [1:0] recs [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_q.push_back({1'b0, 1'b1, recs[i], recs[i], recs[i]});
            bus.ui_in = {P_VALID, sums[i], sums[i], sums[i]};
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests_run++;
                if (bus.uo_out !== 8'h3F) begin
                    failed++;
                    $display("FAIL stall_hold[%0d]: got %h expected 3f", k, bus.uo_out);
                end
            end
            bus.ui_in = {1'b0, k[0], 6'($urandom_range(0, 63))};
        end
        for (int i = 3; i < 5; i++) begin
            @(negedge clk);
            if (i == 3) begin
                tests_run++;
                if (bus.uo_out !== 8'h3F) begin
                    failed++;
                    $display("FAIL stall_hold_last: got %h expected 3f", bus.uo_out);
                end
            end
            exp_q.push_back({(i >= 3), 1'b1, recs[i], recs[i], recs[i]});
            bus.ui_in = {P_VALID, sums[i], sums[i], sums[i]};
        end
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL stall_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [1:0] sums [3] = '{2'd3, 2'd0, 2'd1};
        logic [1:0] recs [3] = '{2'd3, 2'd1, 2'd1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_q.push_back({1'b0, 1'b1, recs[i], recs[i], recs[i]});
            bus.ui_in = {P_VALID, sums[i], sums[i], sums[i]};
        end
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL wrap_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_soft_clear();
        do_reset();
        @(negedge clk);
        exp_q.push_back({2'b01, 2'd1, 2'd1, 2'd1});
        bus.ui_in = {P_VALID, 2'd1, 2'd1, 2'd1};
        @(negedge clk);
        exp_q.push_back({2'b01, 2'd2, 2'd2, 2'd2});
        bus.ui_in = {P_VALID, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        bus.ui_in = {P_CLEAR, 6'b011011};
        @(negedge clk);
        tests_run++;
        if (bus.uo_out !== 8'h00) begin
            failed++;
            $display("FAIL clear_zero: got %h expected 00", bus.uo_out);
        end
        exp_q.push_back({2'b01, 2'd2, 2'd2, 2'd2});
        bus.ui_in = {P_VALID, 2'd2, 2'd2, 2'd2};
        @(negedge clk);
        exp_q.push_back({2'b01, 2'd0, 2'd0, 2'd0});
        bus.ui_in = {P_VALID, 2'd2, 2'd2, 2'd2};
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL clear_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        @(negedge clk);
        exp_q.push_back({2'b01, 2'd3, 2'd2, 2'd1});
        bus.ui_in = {P_VALID, 2'd3, 2'd2, 2'd1};
        @(negedge clk);
        rst_n     = 1'b1;
        bus.ui_in = 8'hFF;
        @(negedge clk);
        rst_n     = 1'b0;
        tests_run++;
        if (bus.uo_out !== 8'h00) begin
            failed++;
            $display("FAIL midreset_zero: got %h expected 00", bus.uo_out);
        end
        exp_q.push_back({2'b01, 2'd2, 2'd2, 2'd2});
        bus.ui_in = {P_VALID, 2'd2, 2'd2, 2'd2};
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL midreset_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_end_to_end();
        logic [1:0] enc_hist [3][4];
        logic [1:0] enc_sum  [3];
        logic [1:0] smp      [3];
        for (int c = 0; c < 3; c++) begin
            enc_sum[c] = 2'd0;
            for (int j = 0; j < 4; j++) enc_hist[c][j] = 2'd0;
        end
        do_reset();
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                bus.ui_in = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
            end
            for (int c = 0; c < 3; c++) begin
                smp[c]     = 2'($urandom_range(0, 3));
                enc_sum[c] = enc_sum[c] + smp[c] - enc_hist[c][0];
                for (int j = 0; j < 3; j++) enc_hist[c][j] = enc_hist[c][j+1];
                enc_hist[c][3] = smp[c];
            end
            @(negedge clk);
            exp_q.push_back({(n >= 3), 1'b1, smp[2], smp[1], smp[0]});
            bus.ui_in = {P_VALID, enc_sum[2], enc_sum[1], enc_sum[0]};
        end
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL e2e_drain: got %0d pending expected 0", exp_q.size());
        end
        tests_run++;
        if (bus.uo_out[7] !== 1'b1) begin
            failed++;
            $display("FAIL e2e_primed: got %b expected 1", bus.uo_out[7]);
        end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_idle_stall();
        test_wrap();
        test_soft_clear();
        test_reset_midstream();
        test_end_to_end();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/window_sum_decoder.md
# window_sum_decoder

Inverse of the windowed moving-sum encoder. Accepts the packed 2-bit running-sum words (x, y, t) that the encoder emits and reconstructs the original 2-bit samples by first-differencing against a WINDOW_SIZE-deep history of previously recovered samples. It sits on the receive side of a chip-to-chip or loopback link, downstream of the encoder's uo_out bus. It reuses the same byte packing and the same p-field gating as the encoder.

## Interface
- WINDOW_SIZE, 4: window depth; must match the encoder's setting; legal range 2..8.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset. Synchronous, active-high: when rst_n=1 at a rising edge the block resets. The port keeps the codebase's name.
- ui_in  in  8  packed input word:
  - [1:0] sum_x, [3:2] sum_y, [5:4] sum_t
  - [7:6] p: 2'b11 = valid word, 2'b10 = soft clear, 2'b00/2'b01 = idle
- uo_out  out  8  registered output:
  - [1:0] x_rec, [3:2] y_rec, [5:4] t_rec
  - [6] out_valid
  - [7] primed

## Operation
- Per channel c, the state is:
  - s_prev (2 bits)
  - hist[0..WINDOW_SIZE-1] (2 bits each); hist[0] is the oldest sample.
- Shared count: width clog2(WINDOW_SIZE)+1, saturating at WINDOW_SIZE.
- Accept (p==2'b11), per channel:
  - d = sum_in − s_prev, mod 4
  - rec = d + hist[0], mod 4
  - shift hist down one place; hist[WINDOW_SIZE-1] ← rec
  - s_prev ← sum_in
  - output field ← rec
- Accept also sets out_valid←1 and count←min(count+1, WINDOW_SIZE).
- All arithmetic is 2-bit unsigned and wraps; there is no saturation and no overflow flag.
- primed = (count == WINDOW_SIZE), registered alongside count. It is informational only: reconstruction is exact from the first accepted word, because the encoder history also starts at zero.
- Soft clear (p==2'b10): same effect as reset.
  - Clears hist, s_prev, count, data fields, out_valid and primed.
  - ui_in[5:0] is ignored on that cycle.
- Idle (p==2'b00 or 2'b01):
  - all state holds; data fields and primed hold
  - out_valid←0
- Reset wins over every p code. There is no other priority, because the p codes are mutually exclusive.
- Exact inversion requires that the decoder sees every encoder word, in order, starting from a common zero state. Dropped or duplicated words corrupt the output until the next clear or reset. This is by design; no error detection.

## Timing
- Reset values: uo_out = 8'h00; all hist, s_prev and count = 0.
- Latency: a word accepted at edge N appears on uo_out after edge N, i.e. one cycle. out_valid is high for exactly that cycle.
- Throughput: one word per cycle. Back-to-back valid words each produce one out_valid pulse, so out_valid stays high continuously.
- Reset or clear mid-stream: takes effect at that edge. On the following cycle uo_out==0. The next valid word is decoded against zero history.
- primed rises on the same edge as the WINDOW_SIZE-th accepted word's output. It stays high until reset or clear.
- Encoder coupling: the encoder's sum register updates each clk. The decoder consumes one word per encoder output cycle with p=2'b11 held.

## Structure
- Shared package holds:
  - WINDOW_SIZE default
  - field offsets: X_LSB=0, Y_LSB=2, T_LSB=4, P_LSB=6
  - P_VALID=2'b11, P_CLEAR=2'b10
- The encoder must import the same package so the packing cannot diverge.
- One sub-module, window_sum_lane: owns hist, s_prev and the difference/add path for one 2-bit channel. Ports: clk, rst_n, clr, acc, sum_in[1:0], rec[1:0]. Instantiated three times.
- The top level owns p decode, count/primed and the uo_out register.

## Test plan
- Reset: assert rst_n=1 for 2 cycles with ui_in=8'hFF -> uo_out=8'h00 throughout and one cycle after release.
- Basic inversion, WINDOW_SIZE=4, x channel:
  - sums 1,3,2,2,2 with p=11 on consecutive cycles -> x_rec = 1,2,3,0,1
  - out_valid high on 5 consecutive cycles; primed rises with the 4th output
- Idle stall: insert 3 cycles of p=00 with garbage sums between the 3rd and 4th words of the basic-inversion sequence -> identical x_rec sequence; out_valid low during the stall; x_rec holds 3.
- Wrap-around: sum sequence 3,0,1 -> x_rec = 3,1,1. Checks that d wraps mod 4.
- Soft clear mid-stream: after 2 words, drive p=10 for one cycle, then sums 2,2 -> uo_out=0 on the cycle after the clear; then x_rec = 2,0; primed low.
- End-to-end: random 200-sample x/y/t stream through the encoder feeding the decoder -> decoded samples equal the encoder inputs, delayed by the fixed pipeline latency, on all three channels.
